// File: rtl/lcd_hd44780_rx.sv
// HD44780-style receiver for the 4-bit LCD bus.
// Tracks the power-up 8-bit -> 4-bit handshake, pairs nibbles into bytes,
// checks E pulse width and busy-gap timing, and mirrors DDRAM writes.
module lcd_hd44780_rx #(
  parameter int FREQ       = 50000000,
  parameter int E_MIN_HIGH = 12,
  parameter int T_NIB_GAP  = 50,
  parameter int T_CMD      = 37,
  parameter int T_CLR      = 1520
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [4:0] LCD_D,
  input  logic       LCD_E,
  output logic       instr_valid,
  output logic       instr_rs,
  output logic [7:0] instr_byte,
  output logic       mode4bit,
  output logic       init_ok,
  output logic       char_we,
  output logic [6:0] char_addr,
  output logic [7:0] char_data,
  output logic       timing_err,
  output logic       proto_err,
  output logic       err_sticky
);

  // Clock cycles per microsecond; every busy limit is scaled from it.
  localparam int T1US = FREQ / 1000000;

  localparam logic [21:0] GAP_PWR0 = 22'(4100 * T1US);
  localparam logic [21:0] GAP_PWR1 = 22'(100 * T1US);
  localparam logic [21:0] GAP_CMD  = 22'(T_CMD * T1US);
  localparam logic [21:0] GAP_CLR  = 22'(T_CLR * T1US);
  localparam logic [21:0] GAP_NIB  = 22'(T_NIB_GAP);
  localparam logic [21:0] GAP_MAX  = 22'h3F_FFFF;
  localparam logic [7:0]  HIGH_MIN = 8'(E_MIN_HIGH);

  typedef enum logic [2:0] {
    PWR0  = 3'd0,
    PWR1  = 3'd1,
    PWR2  = 3'd2,
    PWR3  = 3'd3,
    NIB4  = 3'd4,
    READY = 3'd5
  } stateT;

  // Bus sampling
  logic       eQ, eQq;
  logic [4:0] dQ, dQq;
  logic       eRise, eFall, rsChange;

  // Timing counters
  logic [7:0]  highCnt;
  logic [21:0] gapCnt;
  logic [21:0] reqGap, reqGapNext;

  // Protocol state
  stateT      state, stateNext;
  logic       phaseHigh, phaseHighNext;
  logic [3:0] hiNib, hiNibNext;
  logic       hiRs, hiRsNext;
  logic [6:0] ddramAddr, ddramAddrNext;
  logic       incr, incrNext;
  logic [7:0] fullByte;

  // Output next values
  logic       instrValidNext, instrRsNext, mode4Next, initOkNext;
  logic       charWeNext, timingErrNext, protoErrNext;
  logic [7:0] instrByteNext, charDataNext;
  logic [6:0] charAddrNext;

  assign eRise    = eQ & ~eQq;
  assign eFall    = ~eQ & eQq;
  // dQq lines up with eQq, i.e. the last sample taken while E was still high.
  assign rsChange = eQ & eQq & (dQ[4] != dQq[4]);
  assign fullByte = {hiNib, dQq[3:0]};

  // Register the bus once more to align data with the delayed enable.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      eQ  <= 1'b0;
      eQq <= 1'b0;
      dQ  <= 5'd0;
      dQq <= 5'd0;
    end else begin
      eQ  <= LCD_E;
      eQq <= eQ;
      dQ  <= LCD_D;
      dQq <= dQ;
    end
  end

  // Measure E high width and the idle gap since the last E fall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      highCnt <= 8'd0;
      gapCnt  <= GAP_MAX;
    end else begin
      if (eRise) begin
        highCnt <= 8'd1;
      end else if (eQ && (highCnt != 8'hFF)) begin
        highCnt <= highCnt + 8'd1;
      end
      if (eFall) begin
        gapCnt <= 22'd0;
      end else if (gapCnt != GAP_MAX) begin
        gapCnt <= gapCnt + 22'd1;
      end
    end
  end

  // Decide the next protocol state, model updates and output pulses.
  always_comb begin
    stateNext      = state;
    phaseHighNext  = phaseHigh;
    hiNibNext      = hiNib;
    hiRsNext       = hiRs;
    ddramAddrNext  = ddramAddr;
    incrNext       = incr;
    reqGapNext     = reqGap;
    instrValidNext = 1'b0;
    instrRsNext    = instr_rs;
    instrByteNext  = instr_byte;
    mode4Next      = mode4bit;
    initOkNext     = init_ok;
    charWeNext     = 1'b0;
    charAddrNext   = char_addr;
    charDataNext   = char_data;
    protoErrNext   = 1'b0;
    timingErrNext  = (eRise && (gapCnt < reqGap))
                   || (eFall && (highCnt < HIGH_MIN))
                   || rsChange;

    if (eFall) begin
      case (state)
        PWR0, PWR1, PWR2, PWR3: begin
          case (state)
            PWR0:    reqGapNext = GAP_PWR0;
            PWR1:    reqGapNext = GAP_PWR1;
            default: reqGapNext = GAP_CMD;
          endcase
          if (!dQq[4] && (dQq[3:0] == ((state == PWR3) ? 4'h2 : 4'h3))) begin
            instrValidNext = 1'b1;
            instrRsNext    = 1'b0;
            instrByteNext  = {dQq[3:0], 4'b0000};
            case (state)
              PWR0:    stateNext = PWR1;
              PWR1:    stateNext = PWR2;
              PWR2:    stateNext = PWR3;
              default: stateNext = NIB4;
            endcase
            mode4Next = (state == PWR3) ? 1'b1 : mode4bit;
          end else begin
            protoErrNext = 1'b1;
          end
        end
        NIB4, READY: begin
          if (phaseHigh) begin
            hiNibNext     = dQq[3:0];
            hiRsNext      = dQq[4];
            phaseHighNext = 1'b0;
            reqGapNext    = GAP_NIB;
          end else begin
            phaseHighNext = 1'b1;
            if (!hiRs && (fullByte inside {8'h01, 8'h02, 8'h03})) begin
              reqGapNext = GAP_CLR;
            end else begin
              reqGapNext = GAP_CMD;
            end
            if (dQq[4] != hiRs) begin
              // RS flipped inside a byte: drop the pair.
              protoErrNext = 1'b1;
            end else if (state == NIB4) begin
              // Only a 4-bit Function Set is legal before initialisation completes.
              if (!hiRs && (fullByte[7:5] == 3'b001)) begin
                instrValidNext = 1'b1;
                instrRsNext    = 1'b0;
                instrByteNext  = fullByte;
                initOkNext     = 1'b1;
                stateNext      = READY;
              end else begin
                protoErrNext = 1'b1;
              end
            end else begin
              instrValidNext = 1'b1;
              instrRsNext    = hiRs;
              instrByteNext  = fullByte;
              if (hiRs) begin
                charWeNext    = 1'b1;
                charAddrNext  = ddramAddr;
                charDataNext  = fullByte;
                ddramAddrNext = incr ? (ddramAddr + 7'd1) : (ddramAddr - 7'd1);
              end else if (fullByte == 8'h01) begin
                ddramAddrNext = 7'd0;
                incrNext      = 1'b1;
              end else if ((fullByte == 8'h02) || (fullByte == 8'h03)) begin
                ddramAddrNext = 7'd0;
              end else if (fullByte[7:2] == 6'b000001) begin
                incrNext = fullByte[1];
              end else if (fullByte[7]) begin
                ddramAddrNext = fullByte[6:0];
              end else begin
                ddramAddrNext = ddramAddr;
              end
            end
          end
        end
        default: begin
          stateNext = PWR0;
        end
      endcase
    end else begin
      stateNext = state;
    end
  end

  // State, model and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= PWR0;
      phaseHigh   <= 1'b1;
      hiNib       <= 4'd0;
      hiRs        <= 1'b0;
      ddramAddr   <= 7'd0;
      incr        <= 1'b1;
      reqGap      <= 22'd0;
      instr_valid <= 1'b0;
      instr_rs    <= 1'b0;
      instr_byte  <= 8'd0;
      mode4bit    <= 1'b0;
      init_ok     <= 1'b0;
      char_we     <= 1'b0;
      char_addr   <= 7'd0;
      char_data   <= 8'd0;
      timing_err  <= 1'b0;
      proto_err   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= stateNext;
      phaseHigh   <= phaseHighNext;
      hiNib       <= hiNibNext;
      hiRs        <= hiRsNext;
      ddramAddr   <= ddramAddrNext;
      incr        <= incrNext;
      reqGap      <= reqGapNext;
      instr_valid <= instrValidNext;
      instr_rs    <= instrRsNext;
      instr_byte  <= instrByteNext;
      mode4bit    <= mode4Next;
      init_ok     <= initOkNext;
      char_we     <= charWeNext;
      char_addr   <= charAddrNext;
      char_data   <= charDataNext;
      timing_err  <= timingErrNext;
      proto_err   <= protoErrNext;
      err_sticky  <= err_sticky | timingErrNext | protoErrNext;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Scoreboard bench for lcd_hd44780_rx: accepted bytes are queued as they are
// driven and compared when instr_valid appears; error pulses are counted.
module tb_lcd_hd44780_rx;

  localparam int T1US   = 2;               // FREQ = 2 MHz keeps the run short
  localparam int G_PWR0 = 4100 * T1US;
  localparam int G_PWR1 = 100 * T1US;
  localparam int G_CMD  = 37 * T1US;
  localparam int G_CLR  = 1520 * T1US;
  localparam int G_NIB  = 50;
  localparam int HI     = 20;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [4:0] LCD_D = 5'd0;
  logic       LCD_E = 1'b0;
  logic       instr_valid, instr_rs, mode4bit, init_ok, char_we;
  logic       timing_err, proto_err, err_sticky;
  logic [7:0] instr_byte, char_data;
  logic [6:0] char_addr;

  typedef struct packed {
    logic       rs;
    logic [7:0] b;
    logic       we;
    logic [6:0] addr;
  } expT;

  expT expQ[$];
  int  errors = 0;
  int  checks = 0;
  int  tErrSeen = 0;
  int  pErrSeen = 0;
  int  validSeen = 0;
  int  expTErr = 0;
  int  expPErr = 0;
  int  validMark;

  lcd_hd44780_rx #(.FREQ(2000000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LCD_D(LCD_D), .LCD_E(LCD_E),
    .instr_valid(instr_valid), .instr_rs(instr_rs), .instr_byte(instr_byte),
    .mode4bit(mode4bit), .init_ok(init_ok), .char_we(char_we),
    .char_addr(char_addr), .char_data(char_data), .timing_err(timing_err),
    .proto_err(proto_err), .err_sticky(err_sticky)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pushExp(input logic rs, input logic [7:0] b, input logic we, input logic [6:0] addr);
    expT e;
    e.rs = rs; e.b = b; e.we = we; e.addr = addr;
    expQ.push_back(e);
  endtask

  // Drive one nibble: data set up, E high for hiCyc cycles, then idle gapCyc cycles.
  task automatic pulseNib(input logic rs, input logic [3:0] nib, input int hiCyc, input int gapCyc);
    @(posedge CLK); #1 LCD_D = {rs, nib};
    repeat (2) @(posedge CLK);
    #1 LCD_E = 1'b1;
    repeat (hiCyc) @(posedge CLK);
    #1 LCD_E = 1'b0;
    repeat (gapCyc) @(posedge CLK);
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b, input int gapCyc);
    pulseNib(rs, b[7:4], HI, G_NIB + 5);
    pulseNib(rs, b[3:0], HI, gapCyc);
  endtask

  task automatic sendInstr(input logic [7:0] b, input int gapCyc);
    pushExp(1'b0, b, 1'b0, 7'd0);
    sendByte(1'b0, b, gapCyc);
  endtask

  task automatic sendData(input logic [7:0] b, input logic [6:0] addr);
    pushExp(1'b1, b, 1'b1, addr);
    sendByte(1'b1, b, G_CMD + 5);
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    RESET_N = 1'b0; LCD_E = 1'b0; LCD_D = 5'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkVal("reset_outputs",
             32'({instr_valid, instr_rs, instr_byte, mode4bit, init_ok, char_we,
                  char_addr, char_data, timing_err, proto_err, err_sticky}), 32'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;
  endtask

  task automatic doInit(input int firstGap);
    pushExp(1'b0, 8'h30, 1'b0, 7'd0);
    pulseNib(1'b0, 4'h3, HI, firstGap);
    pushExp(1'b0, 8'h30, 1'b0, 7'd0);
    pulseNib(1'b0, 4'h3, HI, G_PWR1 + 5);
    pushExp(1'b0, 8'h30, 1'b0, 7'd0);
    pulseNib(1'b0, 4'h3, HI, G_CMD + 5);
    checkVal("mode4_before", 32'(mode4bit), 32'd0);
    pushExp(1'b0, 8'h20, 1'b0, 7'd0);
    pulseNib(1'b0, 4'h2, HI, G_CMD + 5);
    checkVal("mode4_after", 32'(mode4bit), 32'd1);
    checkVal("init_ok_before", 32'(init_ok), 32'd0);
    sendInstr(8'h2C, G_CMD + 5);
    checkVal("init_ok_after", 32'(init_ok), 32'd1);
    sendInstr(8'h08, G_CMD + 5);
    sendInstr(8'h01, G_CLR + 5);
    sendInstr(8'h06, G_CMD + 5);
    sendInstr(8'h0C, G_CMD + 5);
  endtask

  // Scoreboard consumer and error-pulse counters, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (timing_err) tErrSeen++;
      if (proto_err) pErrSeen++;
      if (instr_valid) begin
        expT e;
        validSeen++;
        checkVal("sb_has_entry", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkVal("instr_rs", 32'(instr_rs), 32'(e.rs));
          checkVal("instr_byte", 32'(instr_byte), 32'(e.b));
          checkVal("char_we", 32'(char_we), 32'(e.we));
          if (e.we) begin
            checkVal("char_addr", 32'(char_addr), 32'(e.addr));
            checkVal("char_data", 32'(char_data), 32'(e.b));
          end
        end
      end else if (char_we) begin
        checkVal("we_without_valid", 32'(char_we), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    doReset();

    // 1. full initialisation
    validMark = validSeen;
    doInit(G_PWR0 + 5);
    @(negedge CLK);
    checkVal("init_valid_count", 32'(validSeen - validMark), 32'd9);
    checkVal("init_sticky", 32'(err_sticky), 32'd0);

    // 2. data writes after clear
    sendData(8'h41, 7'h00);
    sendData(8'h61, 7'h01);

    // 3. set address, entry mode decrement
    sendInstr(8'hC0, G_CMD + 5);
    sendData(8'h42, 7'h40);
    sendInstr(8'h04, G_CMD + 5);
    sendInstr(8'hC0, G_CMD + 5);
    sendData(8'h44, 7'h40);
    sendData(8'h45, 7'h3F);
    checkVal("terr_none_yet", 32'(tErrSeen), 32'(expTErr));
    checkVal("perr_none_yet", 32'(pErrSeen), 32'(expPErr));

    // 4. clear followed too early by the next E rise
    sendInstr(8'h01, 1000 * T1US - 3);
    expTErr++;
    sendData(8'h46, 7'h00);
    checkVal("clr_gap_terr", 32'(tErrSeen), 32'(expTErr));
    checkVal("clr_gap_sticky", 32'(err_sticky), 32'd1);

    // address wrap at the top of DDRAM
    sendInstr(8'hFF, G_CMD + 5);
    sendData(8'h49, 7'h7F);
    sendData(8'h4A, 7'h00);

    // 5a. short E pulse: flagged but still processed
    pushExp(1'b1, 8'h47, 1'b1, 7'h01);
    pulseNib(1'b1, 4'h4, 5, G_NIB + 5);
    pulseNib(1'b1, 4'h7, HI, G_CMD + 5);
    expTErr++;
    checkVal("short_e_terr", 32'(tErrSeen), 32'(expTErr));
    checkVal("sb_empty_mid", 32'(expQ.size()), 32'd0);

    // 5b. wrong first nibble in PWR0
    doReset();
    validMark = validSeen;
    pulseNib(1'b0, 4'h2, HI, G_PWR0 + 5);
    expPErr++;
    checkVal("pwr0_perr", 32'(pErrSeen), 32'(expPErr));
    checkVal("pwr0_no_valid", 32'(validSeen - validMark), 32'd0);
    checkVal("pwr0_mode4", 32'(mode4bit), 32'd0);
    doInit(G_PWR0 + 5);
    checkVal("pwr0_sticky", 32'(err_sticky), 32'd1);

    // 6. reset after a lone high nibble, then replay init
    pulseNib(1'b0, 4'h2, HI, G_NIB + 5);
    doReset();
    doInit(G_PWR0 + 5);
    sendData(8'h48, 7'h00);
    @(negedge CLK);
    checkVal("replay_sticky", 32'(err_sticky), 32'd0);
    checkVal("replay_init_ok", 32'(init_ok), 32'd1);
    checkVal("final_terr", 32'(tErrSeen), 32'(expTErr));
    checkVal("final_perr", 32'(pErrSeen), 32'(expPErr));
    checkVal("sb_empty_end", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
